regfile_2r1w_sync: RTL
======================

Name: regfile_2r1w_sync

Overview:
- General-purpose register file for the lab datapath: 32 registers, one write port, two registered read ports.
- This block is the reader side of the enabled-register write path. Each register behaves as an enable-gated register on write; the two read ports return stored values with a fixed one-cycle latency and a valid strobe.
- Feeds the operand-fetch stage: rs1/rs2 addresses in, operand values out. Register x0 is hardwired to zero.

Parameters:
WIDTH, 32, data width of each register and of the read/write data ports
DEPTH, 32, number of registers; must be a power of two
AW, 5, address width; must equal log2(DEPTH)

Ports:
clk  input  1  clock; every state change except reset happens on its rising edge
rst_n  input  1  asynchronous, active-low reset
we  input  1  write enable
wa  input  AW  write address
wd  input  WIDTH  write data
rd_en  input  1  read request; samples ra1 and ra2
ra1  input  AW  read address, port 1
ra2  input  AW  read address, port 2
rd1  output  WIDTH  registered read data, port 1
rd2  output  WIDTH  registered read data, port 2
rd_valid  output  1  high for exactly one cycle after each accepted read

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- While rst_n=0:
  - every register entry is 0;
  - rd1=0, rd2=0, rd_valid=0;
  - these values apply immediately, with no clock edge required.
- Reset deassertion takes effect at the next clk rising edge.
- Write: at posedge with we=1 and wa!=0, reg[wa] <= wd.
  - we=1 with wa=0 is ignored; reg[0] stays 0.
  - we=0 leaves all entries unchanged.
- Read: at posedge with rd_en=1:
  - rd1 <= value(ra1), rd2 <= value(ra2);
  - rd_valid <= 1.
- Read latency: exactly 1 cycle. Data and rd_valid are visible after the edge at which rd_en was sampled.
- rd_en=0 at posedge: rd_valid <= 0; rd1 and rd2 hold their previous values. They are not cleared.
- Back-to-back reads: rd_en held high for N cycles gives rd_valid high for N consecutive cycles, with new data every cycle.
- Same-edge write/read forwarding (write-first): if we=1, rd_en=1, wa!=0 and wa==ra1, then rd1 <= wd, not the old contents. The same rule applies independently to ra2/rd2.
- ra1==ra2 is legal; rd1 and rd2 both get the same value.
- Address 0: value(0) is always 0, even when a same-edge write targets wa=0. There is no forwarding for x0.
- Reset asserted mid-operation:
  - an outstanding read is discarded; rd_valid drops immediately and no stale strobe appears after release;
  - a write sampled on the same edge that reset is low is lost.
- Storage must not contain any X after reset. Outputs must never be X once reset has been applied.

Test Plan:
- Reset: drive rst_n=0 for 3 cycles with random we/rd_en. Then read ra1=5, ra2=31 -> rd1=0, rd2=0, rd_valid=1 one cycle later.
- Write then read:
  - write reg[7]=32'hDEADBEEF and reg[12]=32'h00000123 on consecutive cycles;
  - then rd_en with ra1=7, ra2=12 -> rd1=DEADBEEF, rd2=00000123 after 1 cycle, rd_valid pulse of width 1.
- x0 protection: we=1, wa=0, wd=32'hFFFFFFFF; then read ra1=ra2=0 -> rd1=rd2=0.
- Forwarding:
  - reg[3]=32'h11111111;
  - same edge: we=1, wa=3, wd=32'h22222222, rd_en=1, ra1=3, ra2=4 -> rd1=22222222, rd2=0;
  - next read of ra1=3 -> 22222222.
- Hold and valid:
  - read reg[7] (rd1=DEADBEEF), then rd_en=0 for 4 cycles while writing reg[7]=0 -> rd1 stays DEADBEEF, rd_valid=0;
  - 3-cycle rd_en burst -> rd_valid high exactly 3 cycles.
- Mid-read reset: rd_en=1 at an edge, then pull rst_n low 2 ns after the edge -> rd_valid and rd1/rd2 go 0 without a clock; after release, no rd_valid until a new rd_en.

Source files
------------

// File: rtl/regfile_2r1w_sync.sv
// 32-entry, 2-read/1-write register file with registered read ports.
// x0 reads as zero; same-edge writes forward into the read data.
module regfile_2r1w_sync #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic [WIDTH-1:0] wd,
    input  logic             rd_en,
    input  logic [AW-1:0]    ra1,
    input  logic [AW-1:0]    ra2,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2,
    output logic             rd_valid
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [WIDTH-1:0] rd1_q, rd1_d;
    logic [WIDTH-1:0] rd2_q, rd2_d;
    logic             rd_valid_q, rd_valid_d;
    logic [WIDTH-1:0] val1, val2;
    logic             wr_ok;

    assign wr_ok = we && (wa != '0);

    always_comb begin
        mem_d = mem_q;
        if (wr_ok) begin
            mem_d[wa] = wd;
        end
        mem_d[0] = '0;
    end

    // Write-first: a write to the addressed register on this edge wins.
    always_comb begin
        val1 = mem_q[ra1];
        val2 = mem_q[ra2];
        if (wr_ok && (wa == ra1)) begin
            val1 = wd;
        end
        if (wr_ok && (wa == ra2)) begin
            val2 = wd;
        end
        if (ra1 == '0) begin
            val1 = '0;
        end
        if (ra2 == '0) begin
            val2 = '0;
        end
    end

    always_comb begin
        rd1_d      = rd1_q;
        rd2_d      = rd2_q;
        rd_valid_d = rd_en;
        if (rd_en) begin
            rd1_d = val1;
            rd2_d = val2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd1_q      <= '0;
            rd2_q      <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            rd1_q      <= rd1_d;
            rd2_q      <= rd2_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd1      = rd1_q;
    assign rd2      = rd2_q;
    assign rd_valid = rd_valid_q;

endmodule
